// File: rtl/ray_generator_if.sv
// ray_generator_if: ray/t stream pair between the ray generator and the intersection unit
// Ports (signals):
//   ray_axis_tvalid/tready/tdata  ray directions, tdata[0]=x, [1]=y, [2]=z, SIZE bits each
//   t_axis_tvalid/tready/tdata    in-order t results, SIZE bits
// Modports: master = generator side, slave = intersection unit side.
interface ray_generator_if #(
    parameter int SIZE = 64
);
    logic                      ray_axis_tvalid;
    logic                      ray_axis_tready;
    logic [2:0][SIZE-1:0]      ray_axis_tdata;
    logic                      t_axis_tvalid;
    logic                      t_axis_tready;
    logic [SIZE-1:0]           t_axis_tdata;
    modport master (
        output ray_axis_tvalid, ray_axis_tdata, t_axis_tready,
        input  ray_axis_tready, t_axis_tvalid, t_axis_tdata
    );
    modport slave (
        input  ray_axis_tvalid, ray_axis_tdata, t_axis_tready,
        output ray_axis_tready, t_axis_tvalid, t_axis_tdata
    );
endinterface

// File: rtl/ray_generator.sv
// ray_generator: walks the screen in raster order issuing one ray per pixel and pairs returned t values with pixels
// Ports:
//   clk_render  render clock
//   rst         synchronous active-high reset (aborts a frame, drops in-flight rays)
//   start       begin a frame, sampled only while idle
//   busy        high while issuing or draining a frame
//   bus         ray_generator_if.master: ray stream out, t stream in (interface SIZE must equal SIZE here)
//   pixel_valid one-cycle strobe with pixel_x/pixel_y/pixel_t of a returned result
//   frame_done  one-cycle strobe alongside the last pixel of the frame
// Build option: RAY_GEN_FRAME_LOOP_EN restarts the next frame straight after the last result.
module ray_generator #(
    parameter int SIZE            = 64,
    parameter int H_RES           = 320,
    parameter int V_RES           = 180,
    parameter int FOCAL           = 256,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic                       clk_render,
    input  logic                       rst,
    input  logic                       start,
    output logic                       busy,
    ray_generator_if.master            bus,
    output logic                       pixel_valid,
    output logic [$clog2(H_RES)-1:0]   pixel_x,
    output logic [$clog2(V_RES)-1:0]   pixel_y,
    output logic [SIZE-1:0]            pixel_t,
    output logic                       frame_done
);
    localparam int XW = $clog2(H_RES);
    localparam int YW = $clog2(V_RES);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

`ifdef RAY_GEN_FRAME_LOOP_EN
    localparam state_t FRAME_END = RUN;
`else
    localparam state_t FRAME_END = IDLE;
`endif

    state_t        state;
    logic [XW-1:0] ix, rx;
    logic [YW-1:0] iy, ry;
    logic [OW-1:0] outstanding;
    logic          ray_hs, t_hs, i_wrap, i_last, r_wrap, r_last;

    // tvalid depends only on state and credit; credit can only shrink while a ray waits,
    // so a raised tvalid and its (ix,iy)-derived tdata stay put until the handshake.
    assign bus.ray_axis_tvalid = state == RUN && outstanding < OW'(MAX_OUTSTANDING);
    assign bus.t_axis_tready   = outstanding != '0;
    assign bus.ray_axis_tdata  = bus.ray_axis_tvalid
                               ? {SIZE'(FOCAL), SIZE'(V_RES / 2) - SIZE'(iy), SIZE'(ix) - SIZE'(H_RES / 2)}
                               : '0;
    assign busy   = state != IDLE;
    assign ray_hs = bus.ray_axis_tvalid && bus.ray_axis_tready;
    assign t_hs   = bus.t_axis_tvalid && bus.t_axis_tready;
    assign i_wrap = ix == XW'(H_RES - 1);
    assign i_last = i_wrap && iy == YW'(V_RES - 1);
    assign r_wrap = rx == XW'(H_RES - 1);
    assign r_last = r_wrap && ry == YW'(V_RES - 1);

    always_ff @(posedge clk_render) begin
        if (rst) begin
            state       <= IDLE;
            ix          <= '0;
            iy          <= '0;
            rx          <= '0;
            ry          <= '0;
            outstanding <= '0;
            pixel_valid <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            pixel_t     <= '0;
            frame_done  <= 1'b0;
        end else begin
            state <= (state == IDLE && start)          ? RUN
                   : (state == RUN && ray_hs && i_last) ? DRAIN
                   : (state == DRAIN && t_hs && r_last) ? FRAME_END
                   : state;
            outstanding <= outstanding + OW'(ray_hs) - OW'(t_hs);
            pixel_valid <= t_hs;
            frame_done  <= t_hs && r_last;
            if (ray_hs) begin
                ix <= i_wrap ? '0 : ix + XW'(1);
                iy <= i_last ? '0 : i_wrap ? iy + YW'(1) : iy;
            end
            if (t_hs) begin
                pixel_x <= rx;
                pixel_y <= ry;
                pixel_t <= bus.t_axis_tdata;
                rx      <= r_wrap ? '0 : rx + XW'(1);
                ry      <= r_last ? '0 : r_wrap ? ry + YW'(1) : ry;
            end
        end
    end
endmodule
